// File: rtl/histeq_frame_sequencer.sv
// histeq_frame_sequencer
//   Frame-level sequencer for the histogram-equalization IP. Each frame is
//   read twice over the AXI read channel: pass 0 feeds the histogram, a CDF
//   step builds the LUT, pass 1 feeds the pixel mapper whose output is
//   written back through fixed-length write bursts. o_intr is raised once
//   every write burst of the frame has been acknowledged.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//   start, src_addr, dst_addr      : run request and frame base addresses
//   o_intr, pass_sel               : frame done, active pass (0 hist, 1 map)
//   hist_clear, cdf_start, cdf_done: histogram/CDF engine handshake
//   m_ar*, m_r*                    : AXI read address / read data control
//   m_aw*, pix_valid, m_wready,
//   m_wlast, m_b*                  : AXI write address / data / response
//
// state   | meaning
// IDLE    | waiting for start
// H_AR    | histogram pass, read address pending
// H_R     | histogram pass, receiving read burst
// CDF     | CDF/LUT computation running
// M_AR    | map pass, read address pending
// M_R     | map pass, receiving read burst
// DRAIN   | all reads done, waiting for outstanding write responses
// DONE    | frame complete, o_intr held until start drops

module histeq_frame_sequencer #(
  parameter int IMG_BYTES   = 307200,
  parameter int BURST_BEATS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              o_intr,
  output logic              pass_sel,
  output logic              hist_clear,
  output logic              cdf_start,
  input  logic              cdf_done,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic              m_awvalid,
  input  logic              m_awready,
  input  logic              pix_valid,
  input  logic              m_wready,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready
);

  localparam int NB = IMG_BYTES / (BURST_BEATS * 4);
  localparam int CW = $clog2(NB + 1);
  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  localparam logic [CW-1:0]     NB_C        = CW'(NB);
  localparam logic [CW-1:0]     LAST_K      = CW'(NB - 1);
  localparam logic [CW-1:0]     K_ONE       = CW'(1);
  localparam logic [BW-1:0]     BEAT_LAST   = BW'(BURST_BEATS - 1);
  localparam logic [BW-1:0]     B_ONE       = BW'(1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * 4);
  localparam logic [7:0]        LEN_C       = 8'(BURST_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_H_AR, S_H_R, S_CDF, S_M_AR, S_M_R, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [CW-1:0]     rd_k_q, ar_cnt_q, aw_k_q, b_cnt_q;
  logic [BW-1:0]     wbeat_q, wbeat_d;
  logic              arvalid_q, rready_q, awvalid_q;
  logic              pass_sel_q, hist_clear_q, cdf_start_q, intr_q, bready_q;
  logic [7:0]        arlen_q, awlen_q;
  logic              w_accept;
  logic              aw_issue_d;

  assign w_accept   = pix_valid && m_wready;
  assign wbeat_d    = (wbeat_q == BEAT_LAST) ? '0 : wbeat_q + B_ONE;
  // A write burst may only be announced once its source burst has been
  // requested in the map pass.
  assign aw_issue_d = (aw_k_q < ar_cnt_q) && (aw_k_q < NB_C);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      rd_k_q       <= '0;
      ar_cnt_q     <= '0;
      aw_k_q       <= '0;
      b_cnt_q      <= '0;
      wbeat_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      pass_sel_q   <= 1'b0;
      hist_clear_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      intr_q       <= 1'b0;
      bready_q     <= 1'b0;
      arlen_q      <= '0;
      awlen_q      <= '0;
    end else begin
      hist_clear_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      bready_q     <= 1'b1;
      arlen_q      <= LEN_C;
      awlen_q      <= LEN_C;

      // Write side runs alongside the map-pass reads. The state case below
      // only touches these counters while pass_sel is low, so the two never
      // collide.
      if (pass_sel_q) begin
        if (awvalid_q) begin
          if (m_awready) begin
            awvalid_q <= 1'b0;
            aw_k_q    <= aw_k_q + K_ONE;
            awaddr_q  <= awaddr_q + BURST_BYTES;
          end
        end else if (aw_issue_d) begin
          awvalid_q <= 1'b1;
        end
        if (w_accept) wbeat_q <= wbeat_d;
        if (m_bvalid && (b_cnt_q < NB_C)) b_cnt_q <= b_cnt_q + K_ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            araddr_q     <= src_addr;
            awaddr_q     <= dst_addr;
            rd_k_q       <= '0;
            ar_cnt_q     <= '0;
            aw_k_q       <= '0;
            b_cnt_q      <= '0;
            wbeat_q      <= '0;
            hist_clear_q <= 1'b1;
            arvalid_q    <= 1'b1;
            state_q      <= S_H_AR;
          end
        end
        S_H_AR, S_M_AR: begin
          if (arvalid_q && m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            if (state_q == S_M_AR) begin
              ar_cnt_q <= ar_cnt_q + K_ONE;
              state_q  <= S_M_R;
            end else begin
              state_q  <= S_H_R;
            end
          end
        end
        S_H_R, S_M_R: begin
          if (m_rvalid && m_rlast) begin
            rready_q <= 1'b0;
            rd_k_q   <= rd_k_q + K_ONE;
            if (rd_k_q < LAST_K) begin
              araddr_q  <= araddr_q + BURST_BYTES;
              arvalid_q <= 1'b1;
              state_q   <= (state_q == S_H_R) ? S_H_AR : S_M_AR;
            end else if (state_q == S_H_R) begin
              cdf_start_q <= 1'b1;
              state_q     <= S_CDF;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_CDF: begin
          if (cdf_done) begin
            pass_sel_q <= 1'b1;
            rd_k_q     <= '0;
            araddr_q   <= src_q;
            arvalid_q  <= 1'b1;
            state_q    <= S_M_AR;
          end
        end
        S_DRAIN: begin
          if (b_cnt_q == NB_C) begin
            intr_q     <= 1'b1;
            pass_sel_q <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            intr_q   <= 1'b0;
            rd_k_q   <= '0;
            ar_cnt_q <= '0;
            aw_k_q   <= '0;
            b_cnt_q  <= '0;
            wbeat_q  <= '0;
            awaddr_q <= dst_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_intr     = intr_q;
  assign pass_sel   = pass_sel_q;
  assign hist_clear = hist_clear_q;
  assign cdf_start  = cdf_start_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;
  assign m_awaddr   = awaddr_q;
  assign m_awlen    = awlen_q;
  assign m_awvalid  = awvalid_q;
  assign m_bready   = bready_q;
  // Combinational so the last beat is flagged in the same cycle it is offered.
  assign m_wlast    = pix_valid && (wbeat_q == BEAT_LAST);

endmodule
